mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one word-addressed, combinational-read memory between two requesters:
//  instruction fetch (IF) and load/store (LS). Round-robin arbitration, valid/ready
//  handshakes, one outstanding access, registered response.
//  Sits between the CPU front/back end and the memory; owns the memory address/write bus.
// PARAMETERS
//  ADDR_W       32  byte-address width
//  DATA_W       32  word width
//  DEPTH_WORDS  16  number of memory words; word index = addr >> 2
// PORTS
//  clk             in   1       single clock, rising edge
//  rst             in   1       asynchronous, active-high reset
//  if_req_valid    in   1       IF read request
//  if_req_ready    out  1       IF request accepted this cycle
//  if_req_addr     in   ADDR_W  IF byte address
//  if_resp_valid   out  1       IF response available
//  if_resp_ready   in   1       IF consumes response
//  if_resp_data    out  DATA_W  IF read data
//  if_resp_err     out  1       IF misaligned/out-of-range
//  ls_req_valid    in   1       LS request
//  ls_req_ready    out  1       LS request accepted this cycle
//  ls_req_addr     in   ADDR_W  LS byte address
//  ls_req_we       in   1       LS write (1) / read (0)
//  ls_req_wdata    in   DATA_W  LS write data
//  ls_resp_valid   out  1       LS response available (reads and writes)
//  ls_resp_ready   in   1       LS consumes response
//  ls_resp_data    out  DATA_W  LS read data (0 for writes)
//  ls_resp_err     out  1       LS misaligned/out-of-range
//  mem_addr        out  ADDR_W  byte address to memory
//  mem_rdata       in   DATA_W  combinational read data from memory
//  mem_we          out  1       one-cycle write strobe
//  mem_wdata       out  DATA_W  write data to memory
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, last_grant=LS, all *_ready/*_resp_valid/*_err=0,
//    resp data=0, mem_we=0, mem_addr=0.
//  - FSM IDLE: winner chosen combinationally; only winner's req_ready=1. Accept = valid&ready.
//    On accept: capture mem_rdata (or 0 for write/err) and err into resp regs,
//    record owner, last_grant<=winner, go RESP. No accept -> stay IDLE.
//  - FSM RESP: owner's resp_valid=1, data/err stable; both req_ready=0.
//    On owner resp_valid&resp_ready -> IDLE. Throughput: 1 access / 2 cycles min.
//  - Latency: accept in cycle N -> resp_valid in cycle N+1.
//  - Arbitration: single requester wins; both valid -> the one not in last_grant.
//    After reset IF wins first tie. No starvation: alternate under continuous contention.
//  - mem_addr = winner's address in IDLE with a valid request, else 0.
//  - err = addr[1:0]!=0 OR (addr>>2) >= DEPTH_WORDS. Err access: data=0, mem_we never asserted.
//  - mem_we=1 only in the accept cycle of a valid, error-free LS write; mem_wdata=ls_req_wdata
//    then, else 0.
//  - Requesters must hold valid/addr/we/wdata stable until ready; requester dropping valid
//    before ready is legal (not accepted, no side effects).
//  - Reset mid-RESP: pending response discarded; no write is replayed.
//  - Address wrap: no wrap; any index >= DEPTH_WORDS errors (address 0xFFFF_FFFC -> err).
// STRUCTURE
//  - Package mem_arb_pkg: typedef enum {ARB_IDLE, ARB_RESP} arb_state_t;
//    typedef enum logic {PORT_IF=1'b0, PORT_LS=1'b1} port_id_t; function addr_err().
//  - Sub-module mem_rr_pick: 2-way round-robin picker (req[1:0], last -> gnt one-hot), comb.
//  - Top: FSM, response registers, memory bus mux.
// TESTING
//  1. Reset, IF req addr 0x0, mem_rdata=0x003100B3 -> if_req_ready same cycle,
//     if_resp_valid next cycle, data 0x003100B3, err 0.
//  2. IF and LS both valid every cycle, resp_ready=1 -> grants IF,LS,IF,LS each 2 cycles.
//  3. LS write addr 0x8 data 0xDEADBEEF -> mem_we=1 exactly one cycle, mem_addr=0x8,
//     ls_resp_valid next cycle with data 0, err 0.
//  4. LS write addr 0x6 and IF read 0x40 -> both err=1, mem_we stays 0, resp data 0.
//  5. IF resp_ready=0 for 5 cycles -> resp_valid/data held, both req_ready=0 throughout.
//  6. Assert rst during RESP -> all outputs 0 immediately, next IF-LS tie grants IF.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and address checking for the memory port arbiter
package mem_arb_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH_WORDS = 16;

  typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_t;

  typedef enum logic {PORT_IF = 1'b0, PORT_LS = 1'b1} port_id_t;

  // Addresses never wrap: any word index past the end is an error, as is a misaligned byte address.
  function automatic logic addr_err(input logic [63:0] addr, input logic [63:0] depth_words);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth_words);
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// rtl/mem_rr_pick.sv - two-way round-robin picker, combinational
// Bit 0 is instruction fetch, bit 1 is load/store; on a tie the port not granted last wins.
module mem_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  port_id_t   i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = (i_last == PORT_IF) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one combinational-read memory between IF and LS requesters
// One outstanding access; the response is registered and held until its owner consumes it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req_valid,
  output logic              o_if_req_ready,
  input  logic [ADDR_W-1:0] i_if_req_addr,
  output logic              o_if_resp_valid,
  input  logic              i_if_resp_ready,
  output logic [DATA_W-1:0] o_if_resp_data,
  output logic              o_if_resp_err,
  input  logic              i_ls_req_valid,
  output logic              o_ls_req_ready,
  input  logic [ADDR_W-1:0] i_ls_req_addr,
  input  logic              i_ls_req_we,
  input  logic [DATA_W-1:0] i_ls_req_wdata,
  output logic              o_ls_resp_valid,
  input  logic              i_ls_resp_ready,
  output logic [DATA_W-1:0] o_ls_resp_data,
  output logic              o_ls_resp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  port_id_t          r_last;
  port_id_t          r_owner;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_idle;
  logic              w_accept;
  logic              w_win_ls;
  logic              w_win_we;
  logic              w_win_err;
  logic              w_mem_we;
  logic              w_owner_taken;
  logic              w_if_owns;
  logic              w_ls_owns;
  logic [ADDR_W-1:0] w_win_addr;

  // Reset also gates the combinational handshake so nothing is granted while rst is high.
  assign w_idle = (r_state == ARB_IDLE) && !i_rst;
  assign w_req  = {i_ls_req_valid, i_if_req_valid};

  mem_rr_pick u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_accept   = w_idle && (w_gnt != 2'b00);
  assign w_win_ls   = w_gnt[1];
  assign w_win_addr = w_win_ls ? i_ls_req_addr : i_if_req_addr;
  assign w_win_we   = w_win_ls && i_ls_req_we;
  assign w_win_err  = addr_err(64'(w_win_addr), 64'(DEPTH_WORDS));
  assign w_mem_we   = w_accept && w_win_we && !w_win_err;

  assign o_if_req_ready = w_idle && w_gnt[0];
  assign o_ls_req_ready = w_idle && w_gnt[1];
  assign o_mem_addr     = w_accept ? w_win_addr : '0;
  assign o_mem_we       = w_mem_we;
  assign o_mem_wdata    = w_mem_we ? i_ls_req_wdata : '0;

  assign w_owner_taken = (r_owner == PORT_IF) ? i_if_resp_ready : i_ls_resp_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: if (w_accept) w_next_state = ARB_RESP;
      ARB_RESP: if (w_owner_taken) w_next_state = ARB_IDLE;
      default:  w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ARB_IDLE;
      r_last      <= PORT_LS;
      r_owner     <= PORT_IF;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_owner     <= port_id_t'(w_win_ls);
        r_last      <= port_id_t'(w_win_ls);
        r_resp_err  <= w_win_err;
        r_resp_data <= (w_win_err || w_win_we) ? '0 : i_mem_rdata;
      end
    end
  end

  assign w_if_owns = (r_state == ARB_RESP) && (r_owner == PORT_IF);
  assign w_ls_owns = (r_state == ARB_RESP) && (r_owner == PORT_LS);

  assign o_if_resp_valid = w_if_owns;
  assign o_if_resp_data  = w_if_owns ? r_resp_data : '0;
  assign o_if_resp_err   = w_if_owns && r_resp_err;
  assign o_ls_resp_valid = w_ls_owns;
  assign o_ls_resp_data  = w_ls_owns ? r_resp_data : '0;
  assign o_ls_resp_err   = w_ls_owns && r_resp_err;

endmodule
